// File: rtl/ms_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ms_sram_pkg
// Description : Shared defaults and level/bit conversion helpers for the
//               mixed-signal SRAM behavioural model.
//               - ANA_WIDTH_DEF / FULL_SCALE_DEF / THRESHOLD_DEF: default
//                 analog-code width, logic-1 rail code and slicing threshold.
//               - to_bit   : analog level code -> logic bit (code >= thresh).
//               - to_level : logic bit -> rail code (0 or full scale).
// Revision    : 1.0 - initial release
// ============================================================================
package ms_sram_pkg;

    localparam int ANA_WIDTH_DEF  = 8;
    localparam int FULL_SCALE_DEF = (2 ** ANA_WIDTH_DEF) - 1;
    localparam int THRESHOLD_DEF  = 2 ** (ANA_WIDTH_DEF - 1);

    // Unsigned compare with no hysteresis. Operands are carried at 32 bits so
    // the helpers work for any ANA_WIDTH up to 32; callers zero-extend codes.
    function automatic logic to_bit(input logic [31:0] code,
                                    input logic [31:0] threshold);
        return (code >= threshold);
    endfunction

    // Only the two rail codes are ever produced; callers size the result
    // down to their own ANA_WIDTH.
    function automatic logic [31:0] to_level(input logic        b,
                                             input logic [31:0] full_scale);
        return b ? full_scale : 32'd0;
    endfunction

endpackage : ms_sram_pkg
`default_nettype wire

// File: rtl/ana_slicer.sv
`default_nettype none
// ============================================================================
// Module      : ana_slicer
// Description : Converts an array of analog level codes into a packed logic
//               vector by comparing each code against THRESHOLD. Purely
//               combinational.
// Ports       : lvl_i  [LANES] x [ANA_WIDTH-1:0] - input level codes
//               bits_o [LANES-1:0]              - sliced logic bits
//                                                 (bits_o[i] from lvl_i[i])
// Revision    : 1.0 - initial release
// ============================================================================
module ana_slicer
    import ms_sram_pkg::*;
#(
    parameter int LANES     = 1,
    parameter int ANA_WIDTH = ANA_WIDTH_DEF,
    parameter int THRESHOLD = THRESHOLD_DEF
) (
    input  logic [ANA_WIDTH-1:0] lvl_i [LANES],
    output logic [LANES-1:0]     bits_o
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign bits_o[i] = to_bit(32'(lvl_i[i]), 32'(THRESHOLD));
    end

endmodule : ana_slicer
`default_nettype wire

// File: rtl/mixed_signal_sram.sv
`default_nettype none
// ============================================================================
// Module      : mixed_signal_sram
// Description : Single-port, read-first synchronous SRAM whose pins carry
//               analog level codes. Inputs are sliced to logic against a
//               mid-scale threshold; read data is driven back as rail codes
//               (0 / FULL_SCALE).
// Ports       : clk_a  [ANA_WIDTH-1:0]              - clock level code
//               rst_a  [ANA_WIDTH-1:0]              - sync active-high reset
//               we_a   [ANA_WIDTH-1:0]              - write-enable level
//               addr_a [ADDR_WIDTH] x [ANA_WIDTH-1:0] - address bit levels
//               din_a  [DATA_WIDTH] x [ANA_WIDTH-1:0] - write-data bit levels
//               dout_a [DATA_WIDTH] x [ANA_WIDTH-1:0] - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module mixed_signal_sram
    import ms_sram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int ANA_WIDTH  = ANA_WIDTH_DEF,
    parameter int FULL_SCALE = (2 ** ANA_WIDTH) - 1,
    parameter int THRESHOLD  = 2 ** (ANA_WIDTH - 1)
) (
    input  logic [ANA_WIDTH-1:0] clk_a,
    input  logic [ANA_WIDTH-1:0] rst_a,
    input  logic [ANA_WIDTH-1:0] we_a,
    input  logic [ANA_WIDTH-1:0] addr_a [ADDR_WIDTH],
    input  logic [ANA_WIDTH-1:0] din_a  [DATA_WIDTH],
    output logic [ANA_WIDTH-1:0] dout_a [DATA_WIDTH]
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // ------------------------------------------------------------------
    // Input slicing
    // ------------------------------------------------------------------
    logic [ANA_WIDTH-1:0] clk_lvl [1];
    logic [ANA_WIDTH-1:0] rst_lvl [1];
    logic [ANA_WIDTH-1:0] we_lvl  [1];

    assign clk_lvl[0] = clk_a;
    assign rst_lvl[0] = rst_a;
    assign we_lvl[0]  = we_a;

    logic                  clk;
    logic                  rst;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;

    // The sliced clock is the only clock in the block; every register below
    // is clocked from it.
    ana_slicer #(
        .LANES     (1),
        .ANA_WIDTH (ANA_WIDTH),
        .THRESHOLD (THRESHOLD)
    ) u_clk_slicer (
        .lvl_i  (clk_lvl),
        .bits_o (clk)
    );

    ana_slicer #(
        .LANES     (1),
        .ANA_WIDTH (ANA_WIDTH),
        .THRESHOLD (THRESHOLD)
    ) u_rst_slicer (
        .lvl_i  (rst_lvl),
        .bits_o (rst)
    );

    ana_slicer #(
        .LANES     (1),
        .ANA_WIDTH (ANA_WIDTH),
        .THRESHOLD (THRESHOLD)
    ) u_we_slicer (
        .lvl_i  (we_lvl),
        .bits_o (we)
    );

    ana_slicer #(
        .LANES     (ADDR_WIDTH),
        .ANA_WIDTH (ANA_WIDTH),
        .THRESHOLD (THRESHOLD)
    ) u_addr_slicer (
        .lvl_i  (addr_a),
        .bits_o (addr)
    );

    ana_slicer #(
        .LANES     (DATA_WIDTH),
        .ANA_WIDTH (ANA_WIDTH),
        .THRESHOLD (THRESHOLD)
    ) u_din_slicer (
        .lvl_i  (din_a),
        .bits_o (din)
    );

    // ------------------------------------------------------------------
    // Storage and read-first output register
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] dout_d;
    logic [DATA_WIDTH-1:0] dout_q;

    // The read samples the array as it stands before this edge's write, so a
    // write to the addressed word returns the old contents.
    always_comb begin
        dout_d = mem_q[addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Whole array is cleared and any concurrent write is dropped.
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
            if (we) begin
                mem_q[addr] <= din;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output level encoder: only rail codes are ever driven.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_dout
        assign dout_a[i] = ANA_WIDTH'(to_level(dout_q[i], 32'(FULL_SCALE)));
    end

endmodule : mixed_signal_sram
`default_nettype wire

// File: tb/tb_mixed_signal_sram.sv
`default_nettype none
// ============================================================================
// Module      : tb_mixed_signal_sram
// Description : Self-checking bench for mixed_signal_sram. A word-level
//               model of the memory predicts the read data every cycle; a
//               set of hand-computed literals pins both DUT and model at
//               key points of the directed sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mixed_signal_sram;

    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int ADW = 4;
    localparam int TH  = 128;

    logic          tclk = 1'b0;
    logic [AW-1:0] clk_a;
    logic [AW-1:0] rst_a;
    logic [AW-1:0] we_a;
    logic [AW-1:0] addr_a [ADW];
    logic [AW-1:0] din_a  [DW];
    logic [AW-1:0] dout_a [DW];

    int checks = 0;
    int errors = 0;

    assign clk_a = tclk ? 8'd255 : 8'd0;

    always #5 tclk = ~tclk;

    mixed_signal_sram #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (ADW),
        .ANA_WIDTH  (AW),
        .FULL_SCALE (255),
        .THRESHOLD  (TH)
    ) dut (
        .clk_a  (clk_a),
        .rst_a  (rst_a),
        .we_a   (we_a),
        .addr_a (addr_a),
        .din_a  (din_a),
        .dout_a (dout_a)
    );

    // ------------------------------------------------------------------
    // Word-level model: codes are interpreted by the threshold rule, the
    // memory is a plain array and reads see the pre-write contents.
    // ------------------------------------------------------------------
    logic [7:0] m_mem [16];
    logic [7:0] m_dout;
    bit         m_valid = 1'b0;

    always @(posedge tclk) begin
        int         a;
        logic [7:0] d;
        a = 0;
        d = '0;
        for (int i = 0; i < ADW; i++) if (addr_a[i] >= TH) a += (1 << i);
        for (int i = 0; i < DW; i++)  d[i] = (din_a[i] >= TH);
        if (rst_a >= TH) begin
            for (int k = 0; k < 16; k++) m_mem[k] = 8'h00;
            m_dout  = 8'h00;
            m_valid = 1'b1;
        end else begin
            m_dout = m_mem[a];
            if (we_a >= TH) m_mem[a] = d;
        end
    end

    function automatic logic [63:0] rail(input logic [7:0] b);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = b[i] ? 8'd255 : 8'd0;
        return r;
    endfunction

    function automatic logic [63:0] packed_dout();
        logic [63:0] r;
        for (int i = 0; i < DW; i++) r[i*8 +: 8] = dout_a[i];
        return r;
    endfunction

    // Per-cycle compare, on the falling edge, once reset has defined state.
    always @(negedge tclk) begin
        if (m_valid) begin
            checks++;
            if (packed_dout() !== rail(m_dout)) begin
                errors++;
                $display("FAIL dout_cycle t=%0t actual=%h expected=%h",
                         $time, packed_dout(), rail(m_dout));
            end
        end
    end

    task automatic check_lit(input string name, input logic [7:0] lit);
        checks++;
        if (packed_dout() !== rail(lit)) begin
            errors++;
            $display("FAIL %s dut actual=%h expected=%h",
                     name, packed_dout(), rail(lit));
        end
        checks++;
        if (m_dout !== lit) begin
            errors++;
            $display("FAIL %s model actual=%h expected=%h", name, m_dout, lit);
        end
    endtask

    // One clock edge with the given codes; returns 1 time unit after the
    // rising edge so outputs can be inspected away from the edge.
    task automatic step_c(input logic [7:0] rc, input logic [7:0] wc,
                          input int a, input logic [7:0] d,
                          input logic [7:0] hi, input logic [7:0] lo);
        @(negedge tclk);
        rst_a = rc;
        we_a  = wc;
        for (int i = 0; i < ADW; i++) addr_a[i] = a[i] ? hi : lo;
        for (int i = 0; i < DW; i++)  din_a[i]  = d[i] ? hi : lo;
        @(posedge tclk);
        #1;
    endtask

    task automatic step(input bit r, input bit w, input int a,
                        input logic [7:0] d);
        step_c(r ? 8'd255 : 8'd0, w ? 8'd255 : 8'd0, a, d, 8'd255, 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = '0;
        we_a  = '0;
        for (int i = 0; i < ADW; i++) addr_a[i] = '0;
        for (int i = 0; i < DW; i++)  din_a[i]  = '0;

        // Reset, then reads of both ends of the array.
        step(1, 0, 0, 8'h00);  check_lit("reset",        8'h00);
        step(0, 0, 0, 8'h00);  check_lit("rd0_after_rst", 8'h00);
        step(0, 0, 15, 8'h00); check_lit("rd15_after_rst", 8'h00);

        // Write then read; read-first overwrite.
        step(0, 1, 2, 8'hA5);  check_lit("wr_a5_old",    8'h00);
        step(0, 0, 2, 8'h00);  check_lit("rd_a5",        8'hA5);
        step(0, 1, 2, 8'h3C);  check_lit("wr_3c_old",    8'hA5);
        step(0, 0, 2, 8'h00);  check_lit("rd_3c",        8'h3C);

        // Threshold: we=127 must not write; we=128 with data/addr codes at
        // 128/127 must write the sliced pattern.
        step_c(8'd0, 8'd127, 5, 8'hFF, 8'd255, 8'd0);
        check_lit("we127_rd_old", 8'h00);
        step(0, 0, 5, 8'h00);  check_lit("we127_nowrite", 8'h00);
        step_c(8'd0, 8'd128, 5, 8'h96, 8'd128, 8'd127);
        check_lit("we128_rd_old", 8'h00);
        step(0, 0, 5, 8'h00);  check_lit("thr_data",     8'h96);

        // Back-to-back writes to one address.
        step(0, 1, 7, 8'h11);  check_lit("b2b_first",    8'h00);
        step(0, 1, 7, 8'h22);  check_lit("b2b_second",   8'h11);
        step(0, 0, 7, 8'h00);  check_lit("b2b_read",     8'h22);

        // Full sweep: data = ~addr, then read everything back.
        for (int i = 0; i < 16; i++) begin
            logic [7:0] v;
            v = ~8'(i);
            step(0, 1, i, v);
        end
        for (int i = 0; i < 16; i++) begin
            logic [7:0] v;
            v = ~8'(i);
            step(0, 0, i, 8'h00);
            check_lit($sformatf("sweep_rd%0d", i), v);
        end

        // Reset in the middle of a full array clears everything.
        step(0, 0, 9, 8'h00);  check_lit("pre_rst_rd9",  8'hF6);
        step(1, 1, 9, 8'h55);  check_lit("mid_reset",    8'h00);
        step(0, 0, 9, 8'h00);  check_lit("post_rst_rd9", 8'h00);
        step(0, 0, 15, 8'h00); check_lit("post_rst_rd15", 8'h00);
        step(0, 0, 0, 8'h00);  check_lit("post_rst_rd0", 8'h00);

        @(negedge tclk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mixed_signal_sram
`default_nettype wire
